// File: rtl/flt_evt_pkg.sv
//------------------------------------------------------------------------------
// Module  : flt_evt_pkg
// Brief   : Shared constants and threshold helper for the fault-event capture path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package flt_evt_pkg;

    localparam int FLT_CNT_W     = 4;
    localparam int FLT_SYNC_STG  = 2;
    localparam int FLT_THR_W_MAX = 16;

    // A programmed threshold of zero behaves as a single-cycle filter.
    function automatic logic [FLT_THR_W_MAX-1:0] eff_thr(
        input logic [FLT_THR_W_MAX-1:0] thr
    );
        logic [FLT_THR_W_MAX-1:0] res;
        res = (thr == '0) ? FLT_THR_W_MAX'(1) : thr;
        return res;
    endfunction

endpackage : flt_evt_pkg

`default_nettype wire

// File: rtl/flt_dgl_ch.sv
//------------------------------------------------------------------------------
// Module  : flt_dgl_ch
// Brief   : One fault channel: synchroniser, consecutive-cycle deglitch, rise flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module flt_dgl_ch
    import flt_evt_pkg::*;
#(
    parameter int CNT_W    = FLT_CNT_W,
    parameter int SYNC_STG = FLT_SYNC_STG
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] dgl_cyc_i,
    input  logic             raw_i,
    output logic             lvl_o,
    output logic             rise_o
);

    logic [SYNC_STG-1:0]      sync_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic                     lvl_q;
    logic                     lvl_d;
    logic                     rise_q;
    logic                     rise_d;
    logic                     sync_bit;
    logic [FLT_THR_W_MAX-1:0] thr_eff;
    logic [FLT_THR_W_MAX-1:0] cnt_inc;

    // The synchroniser ignores the enable so a line that is already high is
    // seen immediately when capture is re-enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], raw_i};
        end
    end

    assign sync_bit = sync_q[SYNC_STG-1];
    assign thr_eff  = eff_thr(FLT_THR_W_MAX'(dgl_cyc_i));
    assign cnt_inc  = FLT_THR_W_MAX'(cnt_q) + FLT_THR_W_MAX'(1);

    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (!en_i) begin
            cnt_d = '0;
            lvl_d = 1'b0;
        end else if (sync_bit == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_inc >= thr_eff) begin
            lvl_d = sync_bit;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        rise_d = lvl_d & ~lvl_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;

endmodule : flt_dgl_ch

`default_nettype wire

// File: rtl/flt_evt_capture.sv
//------------------------------------------------------------------------------
// Module  : flt_evt_capture
// Brief   : Deglitched fault capture producing one-cycle logic-set strobes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module flt_evt_capture
    import flt_evt_pkg::*;
#(
    parameter int DW       = 8,
    parameter int CNT_W    = FLT_CNT_W,
    parameter int SYNC_STG = FLT_SYNC_STG
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_dgl_cyc,
    input  logic [DW-1:0]    i_flt_raw,
    output logic [DW-1:0]    o_flt_lvl,
    output logic             o_lgc_wen,
    output logic [DW-1:0]    o_lgc_data
);

    logic [DW-1:0] lvl;
    logic [DW-1:0] rise;
    logic          wen_q;
    logic          wen_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    for (genvar gi = 0; gi < DW; gi++) begin : g_ch
        flt_dgl_ch #(
            .CNT_W    (CNT_W),
            .SYNC_STG (SYNC_STG)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .en_i      (i_en),
            .dgl_cyc_i (i_dgl_cyc),
            .raw_i     (i_flt_raw[gi]),
            .lvl_o     (lvl[gi]),
            .rise_o    (rise[gi])
        );
    end

    // Rises landing in the same cycle merge into one strobe; data stays zero
    // whenever the strobe is low.
    always_comb begin
        wen_d  = 1'b0;
        data_d = '0;
        if (i_en) begin
            wen_d  = |rise;
            data_d = rise;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wen_q  <= 1'b0;
            data_q <= '0;
        end else begin
            wen_q  <= wen_d;
            data_q <= data_d;
        end
    end

    assign o_flt_lvl  = lvl;
    assign o_lgc_wen  = wen_q;
    assign o_lgc_data = data_q;

endmodule : flt_evt_capture

`default_nettype wire

// File: tb/tb_flt_evt_capture.sv
//------------------------------------------------------------------------------
// Module  : tb_flt_evt_capture
// Brief   : Directed self-checking bench for flt_evt_capture.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_flt_evt_capture;

    localparam int DW    = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] dgl;
    logic [DW-1:0]    raw;
    logic [DW-1:0]    lvl;
    logic             wen;
    logic [DW-1:0]    data;

    int n_chk;
    int n_fail;

    flt_evt_capture #(
        .DW       (DW),
        .CNT_W    (CNT_W),
        .SYNC_STG (2)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_dgl_cyc  (dgl),
        .i_flt_raw  (raw),
        .o_flt_lvl  (lvl),
        .o_lgc_wen  (wen),
        .o_lgc_data (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Run n cycles, collecting strobe count, OR of strobe data, and any
    // cycle where data is nonzero without a strobe.
    task automatic watch(input int n, output int cnt, output logic [DW-1:0] dor,
                         output int bad);
        cnt = 0;
        dor = '0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (wen === 1'b1) begin
                cnt++;
                dor |= data;
            end else if (data !== '0) begin
                bad++;
            end
        end
    endtask

    int            s_cnt;
    logic [DW-1:0] s_dat;
    int            s_bad;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        dgl    = 4'd4;
        raw    = '0;

        // Reset state
        tick(3);
        check("rst_lvl", 32'(lvl), 32'h0);
        check("rst_wen", 32'(wen), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        rst_n = 1'b1;
        tick(3);

        // 1: N=4, raw[0] held -> level at edge 6, single strobe at edge 7
        raw = 8'h01;
        tick(5);
        check("t1_lvl_e5", 32'(lvl), 32'h00);
        tick();
        check("t1_lvl_e6", 32'(lvl), 32'h01);
        check("t1_wen_e6", 32'(wen), 32'h0);
        tick();
        check("t1_wen_e7", 32'(wen), 32'h1);
        check("t1_data_e7", 32'(data), 32'h01);
        watch(13, s_cnt, s_dat, s_bad);
        check("t1_extra_strobes", 32'(s_cnt), 32'd0);
        raw = 8'h00;
        watch(10, s_cnt, s_dat, s_bad);
        check("t1_fall_no_evt", 32'(s_cnt), 32'd0);
        check("t1_fall_lvl", 32'(lvl), 32'h00);

        // 2: 3-cycle pulse filtered out, 4-cycle pulse passes
        raw = 8'h08;
        tick(3);
        raw = 8'h00;
        watch(12, s_cnt, s_dat, s_bad);
        check("t2_short_strobes", 32'(s_cnt), 32'd0);
        check("t2_short_lvl", 32'(lvl), 32'h00);
        raw = 8'h08;
        watch(4, s_cnt, s_dat, s_bad);
        check("t2_long_early", 32'(s_cnt), 32'd0);
        raw = 8'h00;
        watch(12, s_cnt, s_dat, s_bad);
        check("t2_long_strobes", 32'(s_cnt), 32'd1);
        check("t2_long_data", 32'(s_dat), 32'h08);
        check("t2_data_idle", 32'(s_bad), 32'd0);
        check("t2_long_lvl_back", 32'(lvl), 32'h00);

        // 3: N=2, merged then back-to-back strobes
        dgl = 4'd2;
        tick(2);
        raw = 8'h42;
        tick();
        raw = 8'h46;
        tick(3);
        check("t3_wen_e4", 32'(wen), 32'h0);
        tick();
        check("t3_wen_e5", 32'(wen), 32'h1);
        check("t3_data_e5", 32'(data), 32'h42);
        tick();
        check("t3_wen_e6", 32'(wen), 32'h1);
        check("t3_data_e6", 32'(data), 32'h04);
        tick();
        check("t3_wen_e7", 32'(wen), 32'h0);
        check("t3_data_e7", 32'(data), 32'h00);
        check("t3_lvl", 32'(lvl), 32'h46);
        raw = 8'h00;
        tick(10);

        // 4a: N=0 behaves as N=1
        dgl = 4'd0;
        tick(2);
        raw = 8'h01;
        tick(3);
        check("t4_n0_wen_e3", 32'(wen), 32'h0);
        tick();
        check("t4_n0_wen_e4", 32'(wen), 32'h1);
        check("t4_n0_data_e4", 32'(data), 32'h01);
        raw = 8'h00;
        tick(8);

        // 4b: N=10 lowered to 3 while cnt=6 -> flip on next edge
        dgl = 4'd10;
        tick(2);
        raw = 8'h01;
        tick(8);
        check("t4_n10_lvl_e8", 32'(lvl), 32'h00);
        dgl = 4'd3;
        tick();
        check("t4_relower_lvl", 32'(lvl), 32'h01);
        tick();
        check("t4_relower_wen", 32'(wen), 32'h1);
        check("t4_relower_data", 32'(data), 32'h01);
        raw = 8'h00;
        tick(10);

        // 5: enable gating
        dgl = 4'd4;
        en  = 1'b0;
        raw = 8'hFF;
        watch(8, s_cnt, s_dat, s_bad);
        check("t5_dis_strobes", 32'(s_cnt), 32'd0);
        check("t5_dis_lvl", 32'(lvl), 32'h00);
        en = 1'b1;
        tick(3);
        check("t5_en_lvl_e3", 32'(lvl), 32'h00);
        tick();
        check("t5_en_lvl_e4", 32'(lvl), 32'hFF);
        check("t5_en_wen_e4", 32'(wen), 32'h0);
        tick();
        check("t5_en_wen_e5", 32'(wen), 32'h1);
        check("t5_en_data_e5", 32'(data), 32'hFF);
        tick();
        check("t5_en_wen_e6", 32'(wen), 32'h0);
        en = 1'b0;
        tick();
        check("t5_dis_clear_lvl", 32'(lvl), 32'h00);
        raw = 8'h00;
        watch(6, s_cnt, s_dat, s_bad);
        check("t5_dis_no_evt", 32'(s_cnt), 32'd0);
        en = 1'b1;
        tick(4);

        // 6: reset mid-count, fresh strobe after release
        raw = 8'h01;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("t6_rst_lvl", 32'(lvl), 32'h00);
        check("t6_rst_wen", 32'(wen), 32'h0);
        tick(3);
        check("t6_rst_hold_lvl", 32'(lvl), 32'h00);
        check("t6_rst_hold_data", 32'(data), 32'h00);
        rst_n = 1'b1;
        tick(6);
        check("t6_post_wen_e6", 32'(wen), 32'h0);
        tick();
        check("t6_post_wen_e7", 32'(wen), 32'h1);
        check("t6_post_data_e7", 32'(data), 32'h01);
        watch(10, s_cnt, s_dat, s_bad);
        check("t6_post_extra", 32'(s_cnt), 32'd0);
        check("t6_post_idle_data", 32'(s_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_flt_evt_capture

`default_nettype wire
